// File: rtl/lpc_periph_tdata_reader.sv
// Captures LPC cycle records on READY rising edges, filters them by direction,
// queues them in a FIFO and serialises each record as four bytes on a valid/ready stream.
module lpc_periph_tdata_reader #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [31:0]   tdata_i,
    input  logic          tready_i,
    input  logic          cap_writes_i,
    input  logic          cap_reads_i,
    output logic [7:0]    m_data_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [LW-1:0] fifo_level_o,
    output logic          overflow_o,
    output logic [7:0]    drop_cnt_o,
    input  logic          clr_overflow_i
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_e;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          tready_prev_q;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    state_e        state_q;
    logic [31:0]   rec_q;
    logic [1:0]    idx_q;
    logic [7:0]    m_data_q;
    logic          m_valid_q;

    logic          cap_edge;
    logic          accept;
    logic          fifo_nempty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [31:0]   head;

    // Byte order on the wire: addr high, addr low, data, type.
    function automatic logic [7:0] byte_sel(input logic [31:0] rec, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = rec[31:24];
            2'd1:    b = rec[23:16];
            2'd2:    b = rec[15:8];
            default: b = rec[7:0];
        endcase
        return b;
    endfunction

    // Capture, filter and FIFO bookkeeping.
    always_comb begin
        cap_edge    = tready_i & ~tready_prev_q;
        accept      = cap_edge & ((tdata_i[0] & cap_writes_i) | (~tdata_i[0] & cap_reads_i));
        fifo_nempty = (level_q != '0);
        fifo_full   = (level_q == LW'(DEPTH));
        head        = mem_q[rd_ptr_q];
        pop         = fifo_nempty &
                      ((state_q == ST_IDLE) | ((state_q == ST_SEND) & m_ready_i & (idx_q == 2'd3)));
        push        = accept & (~fifo_full | pop);
        drop        = accept & fifo_full & ~pop;

        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d     = level_q + LW'(push) - LW'(pop);

        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;
        if (clr_overflow_i) begin
            // A drop in the clearing cycle survives as the first count.
            overflow_d = drop;
            drop_cnt_d = 8'(drop);
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tdata_i;
        end
    end

    // Capture edge detector, pointers, level and drop statistics.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tready_prev_q <= 1'b1;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= 8'h00;
        end else begin
            tready_prev_q <= tready_i;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Serializer: pops a record, then walks its four bytes; reloads gaplessly after byte 3.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            rec_q     <= 32'h0;
            idx_q     <= 2'd0;
            m_data_q  <= 8'h00;
            m_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_nempty) begin
                        state_q   <= ST_SEND;
                        rec_q     <= head;
                        idx_q     <= 2'd0;
                        m_data_q  <= head[31:24];
                        m_valid_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (m_ready_i) begin
                        if (idx_q != 2'd3) begin
                            idx_q    <= idx_q + 2'd1;
                            m_data_q <= byte_sel(rec_q, idx_q + 2'd1);
                        end else if (fifo_nempty) begin
                            rec_q    <= head;
                            idx_q    <= 2'd0;
                            m_data_q <= head[31:24];
                        end else begin
                            state_q   <= ST_IDLE;
                            m_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_data_o     = m_data_q;
    assign m_valid_o    = m_valid_q;
    assign fifo_level_o = level_q;
    assign overflow_o   = overflow_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_lpc_periph_tdata_reader.sv
// Bench for lpc_periph_tdata_reader: directed scenarios plus random bursts,
// with an expected-byte queue built from the capture/filter/byte-order rules.
module tb_lpc_periph_tdata_reader;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   tdata = 32'h0;
    logic          tready = 1'b0;
    logic          capw = 1'b1;
    logic          capr = 1'b1;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic          clr = 1'b0;

    int            tests = 0;
    int            fails = 0;
    logic [7:0]    exp_q[$];
    bit            rnd_ready = 1'b0;
    bit            held = 1'b0;
    logic [7:0]    held_data = 8'h00;

    lpc_periph_tdata_reader #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tdata_i        (tdata),
        .tready_i       (tready),
        .cap_writes_i   (capw),
        .cap_reads_i    (capr),
        .m_data_o       (m_data),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .fifo_level_o   (fifo_level),
        .overflow_o     (overflow),
        .drop_cnt_o     (drop_cnt),
        .clr_overflow_i (clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic bit accepts(input logic [31:0] r, input bit w, input bit rd);
        return r[0] ? w : rd;
    endfunction

    task automatic push_frame(input logic [31:0] r);
        exp_q.push_back(r[31:24]);
        exp_q.push_back(r[23:16]);
        exp_q.push_back(r[15:8]);
        exp_q.push_back(r[7:0]);
    endtask

    // One READY pulse carrying r; stored tells the scoreboard to expect its frame.
    task automatic send_rec(input logic [31:0] r, input bit stored);
        if (stored) push_frame(r);
        tdata  = r;
        tready = 1'b1;
        tick();
        tready = 1'b0;
        tick();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid || fifo_level != '0) && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(n < 3000), 32'd1);
        check({tag, "_level"}, 32'(fifo_level), 32'd0);
    endtask

    // Byte monitor: every accepted byte must be the next expected one; stalled bytes must hold.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held && m_valid) check("hold_stable", 32'(m_data), 32'(held_data));
            if (m_valid && m_ready) begin
                check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("byte_value", 32'(m_data), 32'(exp_q.pop_front()));
                held = 1'b0;
            end else if (m_valid) begin
                held      = 1'b1;
                held_data = m_data;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] r;
        int          gaps;
        int          nacc;

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_dropcnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Single write record: latency and byte order
        r = 32'hF0F05A01;
        push_frame(r);
        tdata  = r;
        tready = 1'b1;
        tick();
        check("lat_level_after_capture", 32'(fifo_level), 32'd1);
        check("lat_valid_after_capture", 32'(m_valid), 32'd0);
        tready = 1'b0;
        tick();
        check("lat_valid_2cyc", 32'(m_valid), 32'd1);
        check("lat_first_byte", 32'(m_data), 32'hF0);
        check("lat_level_after_pop", 32'(fifo_level), 32'd0);
        drain("single");

        // READY held high: one frame; held through reset: none
        r = 32'h12345601;
        push_frame(r);
        tdata  = r;
        tready = 1'b1;
        repeat (10) tick();
        check("held_one_frame", 32'(exp_q.size()), 32'd0);
        check("held_idle", 32'(m_valid), 32'd0);
        rst = 1'b1;
        tick();
        check("held_rst_valid", 32'(m_valid), 32'd0);
        rst = 1'b0;
        tick();
        check("held_release_level", 32'(fifo_level), 32'd0);
        repeat (10) tick();
        check("held_release_valid", 32'(m_valid), 32'd0);
        check("held_release_level2", 32'(fifo_level), 32'd0);
        tready = 1'b0;
        tick();

        // Reset in the middle of a stalled transfer discards everything
        m_ready = 1'b0;
        send_rec(32'hAAAA1101, 1'b1);
        send_rec(32'hBBBB2201, 1'b1);
        send_rec(32'hCCCC3301, 1'b1);
        check("midrst_pre_level", 32'(fifo_level), 32'd2);
        rst = 1'b1;
        tick();
        check("midrst_valid", 32'(m_valid), 32'd0);
        check("midrst_level", 32'(fifo_level), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        m_ready = 1'b1;
        tick();
        send_rec(32'h0BAD0C01, 1'b1);
        drain("midrst_after");

        // Direction filter: reads rejected, writes accepted
        capr = 1'b0;
        capw = 1'b1;
        r = 32'h00A5A500;
        send_rec(r, accepts(r, capw, capr));
        check("filt_read_level", 32'(fifo_level), 32'd0);
        check("filt_read_valid", 32'(m_valid), 32'd0);
        r = 32'h0010BB01;
        send_rec(r, accepts(r, capw, capr));
        drain("filter");
        check("filt_overflow", 32'(overflow), 32'd0);
        check("filt_dropcnt", 32'(drop_cnt), 32'd0);
        capr = 1'b1;

        // Overflow: DEPTH+3 records with the sink stalled
        m_ready = 1'b0;
        for (int k = 1; k <= int'(DEPTH) + 3; k++) begin
            r = {8'(8'h30 + k), 8'(k), 8'(8'h50 + k), 8'h01};
            send_rec(r, (k <= int'(DEPTH) + 1));
            check("ovf_level", 32'(fifo_level), 32'((k - 1 < int'(DEPTH)) ? k - 1 : int'(DEPTH)));
            check("ovf_hold_byte0", 32'(m_data), 32'h31);
        end
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_dropcnt", 32'(drop_cnt), 32'd2);

        // Drain back-to-back with no idle cycle between frames
        m_ready = 1'b1;
        gaps = 0;
        for (int i = 0; i < 4 * (int'(DEPTH) + 1); i++) begin
            if (!m_valid) gaps++;
            tick();
        end
        check("b2b_gaps", 32'(gaps), 32'd0);
        check("b2b_all_sent", 32'(exp_q.size()), 32'd0);
        check("b2b_idle_after", 32'(m_valid), 32'd0);
        check("b2b_ovf_sticky", 32'(overflow), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_dropcnt", 32'(drop_cnt), 32'd0);

        // Capture while full in the same cycle as a pop: stored, no overflow
        m_ready = 1'b0;
        for (int k = 1; k <= int'(DEPTH) + 1; k++) begin
            send_rec({8'(8'h70 + k), 8'(k), 8'(8'h90 + k), 8'h01}, 1'b1);
        end
        check("full_level", 32'(fifo_level), 32'(DEPTH));
        m_ready = 1'b1;
        repeat (3) tick();
        r = 32'hDEADBE01;
        push_frame(r);
        tdata  = r;
        tready = 1'b1;
        tick();
        tready  = 1'b0;
        m_ready = 1'b0;
        tick();
        check("poppush_level", 32'(fifo_level), 32'(DEPTH));
        check("poppush_overflow", 32'(overflow), 32'd0);
        check("poppush_dropcnt", 32'(drop_cnt), 32'd0);

        // Drop coinciding with clear leaves a count of one
        send_rec(32'h11110001, 1'b0);
        check("drop1_cnt", 32'(drop_cnt), 32'd1);
        tdata  = 32'h22220001;
        tready = 1'b1;
        clr    = 1'b1;
        tick();
        tready = 1'b0;
        clr    = 1'b0;
        tick();
        check("clrdrop_overflow", 32'(overflow), 32'd1);
        check("clrdrop_cnt", 32'(drop_cnt), 32'd1);

        // Drop counter saturates at 255
        for (int k = 0; k < 300; k++) send_rec(32'($urandom()) | 32'h1, 1'b0);
        check("sat_cnt", 32'(drop_cnt), 32'd255);
        check("sat_overflow", 32'(overflow), 32'd1);
        check("sat_level", 32'(fifo_level), 32'(DEPTH));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("sat_clr_cnt", 32'(drop_cnt), 32'd0);
        m_ready = 1'b1;
        drain("sat_drain");

        // Random bursts, never more outstanding records than FIFO plus shift register
        rnd_ready = 1'b1;
        for (int b = 0; b < 20; b++) begin
            capw = 1'($urandom_range(0, 1));
            capr = 1'($urandom_range(0, 1));
            nacc = 0;
            for (int k = 0; k < int'($urandom_range(1, DEPTH)); k++) begin
                r = $urandom();
                if (accepts(r, capw, capr)) nacc++;
                send_rec(r, accepts(r, capw, capr));
                repeat ($urandom_range(0, 3)) tick();
            end
            drain("rnd");
            check("rnd_overflow", 32'(overflow), 32'd0);
            check("rnd_dropcnt", 32'(drop_cnt), 32'd0);
        end
        rnd_ready = 1'b0;
        m_ready   = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lpc_periph_tdata_reader.md
Name: lpc_periph_tdata_reader

Overview:
- Consumer for the peripheral's 32-bit cycle-record stream (TDATA/READY): one record per completed LPC cycle.
- Captures each record on a fresh READY assertion and filters it by cycle direction.
- Buffers accepted records in a FIFO, then serialises each as 4 bytes over a valid/ready byte stream (UART/debug-port side).
- Runs in the peripheral's LCLK domain; no CDC inside.

Parameters:
- DEPTH, 8, FIFO depth in 32-bit records; power of two, >= 2.
- LW, 4, width of the level output; equals log2(DEPTH)+1.

Ports:
- clk_i  input  1  LPC clock (LCLK domain).
- rst_i  input  1  reset; synchronous, active-high.
- tdata_i  input  32  cycle record: [31:16] address, [15:8] data, [7:0] type (bit0 = 1 write / 0 read, bit1 = 1 memory / 0 I/O, [7:2] reserved).
- tready_i  input  1  record-valid level from the peripheral (READY).
- cap_writes_i  input  1  accept write records.
- cap_reads_i  input  1  accept read records.
- m_data_o  output  8  serialised byte.
- m_valid_o  output  1  byte valid.
- m_ready_i  input  1  downstream accepts byte.
- fifo_level_o  output  LW  records currently stored.
- overflow_o  output  1  sticky; set when a record is dropped because the FIFO is full.
- drop_cnt_o  output  8  dropped-record count; saturates at 255.
- clr_overflow_i  input  1  clears overflow_o and drop_cnt_o.

Behaviour:
- Reset values, applied while rst_i is sampled high:
  - FIFO pointers 0; fifo_level_o 0.
  - m_valid_o 0; m_data_o 0x00.
  - overflow_o 0; drop_cnt_o 0.
  - FSM in IDLE; tready_prev 1.
- Reset mid-operation: the in-flight record and all FIFO contents are discarded. m_valid_o is 0 the cycle after reset is sampled.
- Capture: an edge fires when tready_i==1 and tready_prev==0, where tready_prev is tready_i registered each cycle.
  - Because tready_prev resets to 1, a READY level held through reset release never captures; a new 0->1 transition is required.
  - tdata_i is sampled on the clock edge where the capture edge fires.
  - READY held high for N cycles yields exactly one record.
- Filter: a record is accepted if (bit0==1 and cap_writes_i) or (bit0==0 and cap_reads_i).
  - Filtered records are silently discarded. They do not count as drops.
- Push: an accepted record is written to the FIFO at the capture clock edge.
  - If the FIFO is full and no pop happens in the same cycle, the record is dropped: overflow_o <= 1 and drop_cnt_o increments (saturating at 255).
  - If the FIFO is full and a pop happens in the same cycle, the record is stored and fifo_level_o stays at DEPTH.
- clr_overflow_i: clears overflow_o and drop_cnt_o next cycle. If a drop occurs in the same cycle, the result is overflow_o=1 and drop_cnt_o=1.
- Serializer FSM, two states:
  - IDLE: m_valid_o=0. If the FIFO is non-empty, pop the head into the shift register, set byte index to 0, go to SEND.
  - SEND: m_valid_o=1. Byte order is index 0 = addr[15:8], 1 = addr[7:0], 2 = data, 3 = type.
  - On m_valid_o & m_ready_i with index<3: index increments.
  - On m_valid_o & m_ready_i with index==3: if the FIFO is non-empty, pop the next record and stay in SEND with index 0 (gapless back-to-back); otherwise go to IDLE.
  - m_data_o is stable while m_valid_o & !m_ready_i.
- Latency: record sampled at edge E0 -> fifo_level_o=1 after E0 -> popped at E1 -> first byte valid after E1 (2 cycles), assuming the FSM was in IDLE.
- fifo_level_o counts stored records only. The record held in the shift register is not counted.
- Simultaneous push and pop: the level is unchanged.

Test Plan:
- Reset, then a single write record (tready_i 0->1 with tdata_i=0xF0F05A01, caps both 1, m_ready_i=1) -> bytes F0,F0,5A,01 in order. m_valid_o rises 2 cycles after the capture edge. fifo_level_o returns to 0.
- tready_i held high for 10 cycles with a constant record -> exactly one 4-byte frame. Then assert rst_i with tready_i still high, release it, and keep tready_i high -> no new frame.
- cap_reads_i=0, cap_writes_i=1; send a read record (bit0=0) 0x00A5A500 then a write record 0x0010BB01 -> only 00,10,BB,01 emitted. overflow_o stays 0.
- m_ready_i=0; issue DEPTH+3 write records (levels 1..8) -> fifo_level_o=8, overflow_o=1, drop_cnt_o=2 (the first record sits in the shift register, so 1+8 are stored and 2 dropped). m_data_o holds the first record's byte 0 throughout.
- Continue that scenario: m_ready_i=1 -> the 9 stored records drain back-to-back with no idle cycle between frames. Pulse clr_overflow_i -> overflow_o=0, drop_cnt_o=0.
- Fill FIFO full, then in one cycle fire a capture edge while the FSM pops -> the record is stored, fifo_level_o stays 8, and overflow_o does not set.
